// File: rtl/tt_sweep_capture.sv
// Sequential truth-table reader for a single-output combinational function.
// Walks every minterm in ascending order on fn_x, samples fn_y one full
// cycle later, packs the responses LSB-first into WORD_W-bit words and
// streams them over a valid/ready port. Also counts the ON-set size.
module tt_sweep_capture #(
    parameter int N_IN   = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_IN-1:0]   fn_x,
    input  logic              fn_y,
    output logic [WORD_W-1:0] tt_data,
    output logic              tt_valid,
    input  logic              tt_ready,
    output logic              tt_last,
    output logic [N_IN:0]     onset_count
);

    localparam int N_MIN = 1 << N_IN;
    localparam int B_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    // A word must tile the minterm space exactly; anything else is a
    // configuration mistake and must not elaborate.
    generate
        if ((WORD_W < 1) || (WORD_W > N_MIN) || ((N_MIN % WORD_W) != 0)) begin : g_bad_word_w
            $error("tt_sweep_capture: WORD_W must divide 2**N_IN");
        end
    endgenerate

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SET    = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_PUSH   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [B_W-1:0]  B_LAST = B_W'(WORD_W - 1);
    localparam logic [N_IN:0]   M_LAST = (N_IN + 1)'(N_MIN - 1);

    logic [2:0]        state_reg;
    logic [N_IN:0]     m_reg;       // one bit wider than fn_x so it never wraps
    logic [B_W-1:0]    b_reg;
    logic [WORD_W-1:0] buf_reg;
    logic [WORD_W-1:0] sample_word;
    logic              word_full;
    logic              handshake;
    logic              accept;

    assign accept    = (state_reg == S_IDLE) && start;
    assign word_full = (b_reg == B_LAST);
    assign handshake = (state_reg == S_PUSH) && tt_valid && tt_ready;

    // Word buffer with the current response merged into bit b.
    always_comb begin
        sample_word        = buf_reg;
        sample_word[b_reg] = fn_y;
    end

    // Sweep sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:   if (start) state_reg <= S_SET;
                S_SET:    state_reg <= S_SAMPLE;
                S_SAMPLE: state_reg <= word_full ? S_PUSH : S_SET;
                S_PUSH: begin
                    if (handshake) state_reg <= tt_last ? S_DONE : S_SET;
                end
                S_DONE:   state_reg <= S_IDLE;
                default:  state_reg <= S_IDLE;
            endcase
        end
    end

    // Minterm counter, bit index, word buffer and the minterm drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg   <= '0;
            b_reg   <= '0;
            buf_reg <= '0;
            fn_x    <= '0;
        end else begin
            if (accept) begin
                m_reg   <= '0;
                b_reg   <= '0;
                buf_reg <= '0;
            end
            if (state_reg == S_SET) begin
                fn_x <= m_reg[N_IN-1:0];
            end
            if (state_reg == S_SAMPLE) begin
                buf_reg <= sample_word;
                m_reg   <= m_reg + (N_IN + 1)'(1);
                if (!word_full) begin
                    b_reg <= b_reg + B_W'(1);
                end
            end
            if (handshake) begin
                b_reg   <= '0;
                buf_reg <= '0;
            end
        end
    end

    // Running ON-set total; held after the sweep until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onset_count <= '0;
        end else if (accept) begin
            onset_count <= '0;
        end else if (state_reg == S_SAMPLE) begin
            onset_count <= onset_count + {{N_IN{1'b0}}, fn_y};
        end
    end

    // Output word port: loaded when a word fills, held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_data  <= '0;
            tt_valid <= 1'b0;
            tt_last  <= 1'b0;
        end else begin
            if ((state_reg == S_SAMPLE) && word_full) begin
                tt_data  <= sample_word;
                tt_valid <= 1'b1;
                tt_last  <= (m_reg == M_LAST);
            end else if (handshake) begin
                tt_valid <= 1'b0;
                tt_last  <= 1'b0;
            end
        end
    end

    // Status: busy spans the whole sweep, done pulses once as DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= handshake && tt_last;
            if (accept) begin
                busy <= 1'b1;
            end else if (state_reg == S_DONE) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: the function under test is a 256-entry lookup
// table; expected words, ON-set size and handshake/done timing are derived
// from that table and the per-word cycle budget.
module tb_tt_sweep_capture;

    localparam int N_IN   = 8;
    localparam int WORD_W = 32;
    localparam int NMIN   = 256;
    localparam int NWORDS = 8;
    localparam int WCYC   = 2 * WORD_W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              tt_ready = 1'b1;
    logic              fn_y;
    logic              busy;
    logic              done;
    logic              tt_valid;
    logic              tt_last;
    logic [N_IN-1:0]   fn_x;
    logic [WORD_W-1:0] tt_data;
    logic [N_IN:0]     onset_count;
    logic [NMIN-1:0]   lut = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign fn_y = lut[fn_x];

    tt_sweep_capture #(.N_IN(N_IN), .WORD_W(WORD_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .fn_x(fn_x), .fn_y(fn_y), .tt_data(tt_data), .tt_valid(tt_valid),
        .tt_ready(tt_ready), .tt_last(tt_last), .onset_count(onset_count)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ones(input logic [NMIN-1:0] t);
        int n = 0;
        for (int i = 0; i < NMIN; i++) n += int'(t[i]);
        return n;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, longint'({busy, done, tt_valid, tt_last}), 0);
        check({tag, "_fn_x"}, longint'(fn_x), 0);
        check({tag, "_tt_data"}, longint'(tt_data), 0);
        check({tag, "_onset"}, longint'(onset_count), 0);
    endtask

    // One sweep. cyc counts rising edges after the start-sampling edge; all
    // observation happens on the falling edge that follows edge cyc.
    task automatic run_sweep(input string tag, input int stall_word, input int stall_len,
                             input bit rand_bp, input int extra_start_at, input int abort_at,
                             input int exp_onset);
        int cyc, k, stalls, stall_left, done_cyc;
        bit prev_valid, prev_hs;
        logic [WORD_W-1:0] hold_d;
        logic [N_IN-1:0] hold_x;
        @(negedge clk);
        start = 1'b1;
        tt_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = -1; k = 0; stalls = 0; stall_left = stall_len; done_cyc = -1;
        prev_valid = 1'b0; prev_hs = 1'b0; hold_d = '0; hold_x = '0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, "_busy_running"}, longint'(busy), 1);
            if (prev_valid && !prev_hs) begin
                check({tag, "_valid_held"}, longint'(tt_valid), 1);
                check({tag, "_data_held"}, longint'(tt_data), longint'(hold_d));
                check({tag, "_fn_x_held"}, longint'(fn_x), longint'(hold_x));
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({tag, "_done_pulse_end"}, longint'(done), 0);
                check({tag, "_busy_end"}, longint'(busy), 0);
                break;
            end
            if (done === 1'b1 && done_cyc < 0) begin
                done_cyc = cyc;
                check({tag, "_done_cycle"}, longint'(cyc + 1), longint'(NWORDS * WCYC + 1 + stalls));
                check({tag, "_word_count"}, longint'(k), NWORDS);
                check({tag, "_onset"}, longint'(onset_count), longint'(exp_onset));
            end
            start = (cyc == extra_start_at);
            if (cyc == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs({tag, "_abort"});
                start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                tt_ready = 1'b1;
                return;
            end
            if (tt_valid === 1'b1) begin
                if (k == stall_word && stall_left > 0) begin
                    tt_ready = 1'b0;
                    stall_left--;
                end else if (rand_bp) begin
                    tt_ready = ($urandom_range(0, 2) != 0);
                end else begin
                    tt_ready = 1'b1;
                end
                if (!tt_ready) begin
                    stalls++;
                end else begin
                    check({tag, "_word"}, longint'(tt_data), longint'(lut[k*WORD_W +: WORD_W]));
                    check({tag, "_last"}, longint'(tt_last), longint'(k == NWORDS - 1));
                    check({tag, "_hs_cycle"}, longint'(cyc + 1), longint'(WCYC * (k + 1) + stalls));
                    $display("%s word %0d data=%08h last=%0b at edge %0d", tag, k, tt_data, tt_last, cyc + 1);
                    k++;
                end
            end else begin
                tt_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            prev_valid = (tt_valid === 1'b1);
            prev_hs = (tt_valid === 1'b1) && tt_ready;
            hold_d = tt_data;
            hold_x = fn_x;
        end
        start = 1'b0;
        tt_ready = 1'b1;
        if (done_cyc < 0) check({tag, "_timeout"}, 0, 1);
        $display("%s sweep end onset=%0d stalls=%0d", tag, onset_count, stalls);
    endtask

    initial begin
        // Reset state.
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", longint'(busy), 0);

        // Constant zero.
        lut = '0;
        run_sweep("zero", -1, 0, 1'b0, -1, -1, 0);

        // y = x0.
        for (int i = 0; i < NMIN; i++) lut[i] = i[0];
        run_sweep("x0", -1, 0, 1'b0, -1, -1, 128);

        // y = AND of all inputs.
        lut = '0;
        lut[NMIN-1] = 1'b1;
        run_sweep("and", -1, 0, 1'b0, -1, -1, 1);

        // y = x7 with a 10-cycle stall on word 3.
        for (int i = 0; i < NMIN; i++) lut[i] = i[7];
        run_sweep("x7_stall", 3, 10, 1'b0, -1, -1, 128);

        // Random netlist: ignored restart at 100, reset at 200, then fresh sweep.
        for (int i = 0; i < NWORDS; i++) lut[i*WORD_W +: WORD_W] = $urandom();
        run_sweep("abort", -1, 0, 1'b0, 100, 200, 0);
        repeat (2) @(negedge clk);
        check("post_abort_busy", longint'(busy), 0);
        run_sweep("rerun", -1, 0, 1'b0, -1, -1, ones(lut));

        // Random netlists with random backpressure.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NWORDS; i++) lut[i*WORD_W +: WORD_W] = $urandom();
            run_sweep($sformatf("rand%0d", r), -1, 0, 1'b1, -1, -1, ones(lut));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
